rs_alu_station: RTL and testbench
=================================

Name: rs_alu_station

Overview:
- Integer-ALU reservation station that sits directly downstream of the opcode decoder.
- Accepts dispatched instructions carrying the 5-bit RSOP code plus source operands or producer tags.
- Snoops the common data bus (CDB) for missing operands.
- Issues the oldest operand-complete entry to the ALU through a valid/ready handshake.

Parameters:
DEPTH, 4, number of station entries (2..8)
DATA_W, 32, operand/result width
TAG_W, 4, producer tag width (ROB/RS tag)
OP_W, 5, RSOP code width from decoder

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush  in  1  synchronous squash of all entries (branch mispredict)
disp_valid  in  1  dispatch request
disp_ready  out  1  at least one free entry
disp_op  in  OP_W  RSOP code from decoder
disp_dest  in  TAG_W  tag this instruction will broadcast
disp_vj_ok  in  1  operand J value present
disp_vj  in  DATA_W  operand J value
disp_qj  in  TAG_W  operand J producer tag (used when !disp_vj_ok)
disp_vk_ok  in  1  operand K value present (immediate already muxed in by dispatcher)
disp_vk  in  DATA_W  operand K value
disp_qk  in  TAG_W  operand K producer tag
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB producer tag
cdb_data  in  DATA_W  CDB result
iss_valid  out  1  issue candidate present
iss_ready  in  1  ALU accepts
iss_op  out  OP_W  issued RSOP
iss_a  out  DATA_W  operand J
iss_b  out  DATA_W  operand K
iss_dest  out  TAG_W  issued destination tag
count  out  clog2(DEPTH+1)  busy-entry count

Behaviour:
- Reset (rst=1 at edge): all entries cleared to not busy, ages cleared, count=0.
  - Next cycle: disp_ready=1, iss_valid=0.
  - iss_op/iss_a/iss_b/iss_dest=0 whenever iss_valid=0.
- Entry state: busy, op, dest, vj, vj_ok, qj, vk, vk_ok, qk, plus an age matrix.
- Dispatch: on edge with disp_valid && disp_ready, write the lowest-index free entry and mark it youngest.
  - disp_ready is combinational from the busy bits only; it never depends on iss_ready.
  - disp_valid with disp_ready=0 is ignored; the dispatcher holds.
- Dispatch-cycle bypass: if an operand is not ok and cdb_valid && cdb_tag matches its q tag in the same cycle, the entry stores cdb_data with ok=1.
- CDB snoop: every edge, each busy entry with an operand not ok and q==cdb_tag (cdb_valid=1) captures cdb_data and sets ok.
  - One broadcast can wake both operands of several entries.
- Wake-up latency: an operand captured at edge N makes the entry eligible from cycle N+1. There is no combinational CDB-to-issue path.
- Eligible = busy && vj_ok && vk_ok.
  - iss_valid = any eligible.
  - Outputs come from the oldest eligible entry by age matrix, so there are never ties.
- Issue: on edge with iss_valid && iss_ready, that entry becomes free.
  - A freed slot is usable by dispatch from the next cycle.
  - The selected entry stays stable while iss_ready=0 unless an older entry becomes eligible.
- Simultaneous dispatch + issue in one cycle: both take effect; count unchanged.
  - Dispatch uses a slot free before the edge, never the one being issued.
- count: +1 on dispatch, -1 on issue, net on both. It never exceeds DEPTH and never underflows.
- Flush: at the edge, all entries are cleared, count=0, and dispatch/CDB/issue in that cycle are dropped. rst has priority over flush.
- Reset or flush mid-operation discards pending entries; nothing is issued afterward from them.
- RSOP is passed through unmodified. The station does not interpret op codes.

Test Plan:
- Reset then disp_valid with op=00010, vj=5, vk=7, both ok, dest=3 -> iss_valid=1 next cycle with iss_a=5, iss_b=7, iss_dest=3; iss_ready=1 -> count returns 0.
- Dispatch op=00111 with vj_ok=0, qj=9 -> no issue; cdb_valid, tag=9, data=0x20 -> iss_valid rises exactly one cycle later with iss_a=0x20.
- Dispatch with qj=4 in the same cycle as cdb tag=4, data=0xAB -> entry stored ok; issues next cycle with iss_a=0xAB.
- Fill 4 entries holding iss_ready=0, all operands ready -> disp_ready=0, count=4, 5th dispatch ignored, issue order equals dispatch order when iss_ready released.
- Two waiting entries, younger woken first, then older -> younger issues first; once older is eligible it is selected ahead of remaining younger ones.
- 3 busy entries, assert flush with simultaneous dispatch and cdb -> count=0, iss_valid=0, disp_ready=1 next cycle.

Source files
------------

// File: rtl/rs_alu_station.sv
// rs_alu_station: integer-ALU reservation station.
//
// Holds up to DEPTH dispatched instructions, captures missing operands
// from the common data bus, and issues the oldest operand-complete entry
// to the ALU over a valid/ready handshake. The RSOP code is carried
// through untouched.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   flush           synchronous squash of every entry
//   disp_*          dispatch request, operands or producer tags, dest tag
//   disp_ready      at least one free entry (depends on busy bits only)
//   cdb_*           common data bus broadcast (valid, tag, data)
//   iss_*           issue handshake and payload of the selected entry
//   count           number of busy entries
module rs_alu_station #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int OP_W   = 5,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              disp_valid,
  output logic              disp_ready,
  input  logic [OP_W-1:0]   disp_op,
  input  logic [TAG_W-1:0]  disp_dest,
  input  logic              disp_vj_ok,
  input  logic [DATA_W-1:0] disp_vj,
  input  logic [TAG_W-1:0]  disp_qj,
  input  logic              disp_vk_ok,
  input  logic [DATA_W-1:0] disp_vk,
  input  logic [TAG_W-1:0]  disp_qk,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [OP_W-1:0]   iss_op,
  output logic [DATA_W-1:0] iss_a,
  output logic [DATA_W-1:0] iss_b,
  output logic [TAG_W-1:0]  iss_dest,
  output logic [CNT_W-1:0]  count
);

  localparam int IDX_W = $clog2(DEPTH);

  // Control state (reset) and per-entry payload (not reset).
  logic [DEPTH-1:0]  busy_q, busy_d;
  // older_q[i][j] = 1 means entry i was dispatched before entry j.
  logic [DEPTH-1:0]  older_q [DEPTH];
  logic [DEPTH-1:0]  older_d [DEPTH];
  logic [CNT_W-1:0]  count_q, count_d;

  logic [OP_W-1:0]   op_q   [DEPTH];
  logic [OP_W-1:0]   op_d   [DEPTH];
  logic [TAG_W-1:0]  dest_q [DEPTH];
  logic [TAG_W-1:0]  dest_d [DEPTH];
  logic [DATA_W-1:0] vj_q   [DEPTH];
  logic [DATA_W-1:0] vj_d   [DEPTH];
  logic [DATA_W-1:0] vk_q   [DEPTH];
  logic [DATA_W-1:0] vk_d   [DEPTH];
  logic [TAG_W-1:0]  qj_q   [DEPTH];
  logic [TAG_W-1:0]  qj_d   [DEPTH];
  logic [TAG_W-1:0]  qk_q   [DEPTH];
  logic [TAG_W-1:0]  qk_d   [DEPTH];
  logic [DEPTH-1:0]  vj_ok_q, vj_ok_d;
  logic [DEPTH-1:0]  vk_ok_q, vk_ok_d;

  logic [DEPTH-1:0]  eligible;
  logic [DEPTH-1:0]  sel;
  logic              free_found;
  logic [IDX_W-1:0]  free_idx;
  logic              do_disp;
  logic              do_iss;

  // Free-slot search and oldest-eligible select.
  always_comb begin
    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it holding its old value (no latch).
    free_found = 1'b0;
    free_idx   = '0;
    // Descending scan: the last hit, i.e. the lowest free index, wins.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end

    eligible = busy_q & vj_ok_q & vk_ok_q;
    // An eligible entry is selected only if no other eligible entry is older.
    // The age matrix is a total order over busy entries, so sel is one-hot.
    sel = eligible;
    for (int i = 0; i < DEPTH; i++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (j != i && eligible[j] && older_q[j][i]) sel[i] = 1'b0;
      end
    end
  end

  // One-hot OR mux: outputs read as zero whenever nothing is selected.
  always_comb begin
    iss_op   = '0;
    iss_a    = '0;
    iss_b    = '0;
    iss_dest = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (sel[i]) begin
        iss_op   = iss_op   | op_q[i];
        iss_a    = iss_a    | vj_q[i];
        iss_b    = iss_b    | vk_q[i];
        iss_dest = iss_dest | dest_q[i];
      end
    end
  end

  assign disp_ready = free_found;
  assign iss_valid  = |eligible;
  assign do_disp    = disp_valid && disp_ready;
  assign do_iss     = iss_valid && iss_ready;
  assign count      = count_q;

  // Next state: CDB snoop, issue release, dispatch write.
  always_comb begin
    busy_d  = busy_q;
    older_d = older_q;
    op_d    = op_q;
    dest_d  = dest_q;
    vj_d    = vj_q;
    vk_d    = vk_q;
    qj_d    = qj_q;
    qk_d    = qk_q;
    vj_ok_d = vj_ok_q;
    vk_ok_d = vk_ok_q;
    count_d = count_q + CNT_W'(do_disp) - CNT_W'(do_iss);

    if (cdb_valid) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy_q[i] && !vj_ok_q[i] && qj_q[i] == cdb_tag) begin
          vj_ok_d[i] = 1'b1;
          vj_d[i]    = cdb_data;
        end
        if (busy_q[i] && !vk_ok_q[i] && qk_q[i] == cdb_tag) begin
          vk_ok_d[i] = 1'b1;
          vk_d[i]    = cdb_data;
        end
      end
    end

    if (do_iss) busy_d = busy_d & ~sel;

    // The free slot was free before the edge, so it never collides with the
    // entry being issued nor with any snooped entry.
    if (do_disp) begin
      busy_d[free_idx]  = 1'b1;
      op_d[free_idx]    = disp_op;
      dest_d[free_idx]  = disp_dest;
      qj_d[free_idx]    = disp_qj;
      qk_d[free_idx]    = disp_qk;
      // Same-cycle bypass of a matching CDB broadcast.
      vj_ok_d[free_idx] = disp_vj_ok || (cdb_valid && cdb_tag == disp_qj);
      vj_d[free_idx]    = disp_vj_ok ? disp_vj : cdb_data;
      vk_ok_d[free_idx] = disp_vk_ok || (cdb_valid && cdb_tag == disp_qk);
      vk_d[free_idx]    = disp_vk_ok ? disp_vk : cdb_data;
      // Youngest: older than nobody, every other entry is older than it.
      older_d[free_idx] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        if (i != int'(free_idx)) older_d[i][free_idx] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // rst and flush have the same squashing effect, so one branch serves both.
    if (rst || flush) begin
      busy_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      busy_q  <= busy_d;
      older_q <= older_d;
      count_q <= count_d;
    end
  end

  // NOTE: payload storage has no reset; it is only observed through a busy
  // entry, and dispatch rewrites every field before the entry becomes busy.
  always_ff @(posedge clk) begin
    op_q    <= op_d;
    dest_q  <= dest_d;
    vj_q    <= vj_d;
    vk_q    <= vk_d;
    qj_q    <= qj_d;
    qk_q    <= qk_d;
    vj_ok_q <= vj_ok_d;
    vk_ok_q <= vk_ok_d;
  end

endmodule

// File: tb/tb_rs_alu_station.sv
// Self-checking bench for rs_alu_station. A queue in dispatch order models
// the station: the oldest ready instruction is simply the first queue entry
// with both operands present.
module tb_rs_alu_station;

  localparam int DEPTH  = 4;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int OP_W   = 5;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              flush;
  logic              disp_valid;
  logic              disp_ready;
  logic [OP_W-1:0]   disp_op;
  logic [TAG_W-1:0]  disp_dest;
  logic              disp_vj_ok;
  logic [DATA_W-1:0] disp_vj;
  logic [TAG_W-1:0]  disp_qj;
  logic              disp_vk_ok;
  logic [DATA_W-1:0] disp_vk;
  logic [TAG_W-1:0]  disp_qk;
  logic              cdb_valid;
  logic [TAG_W-1:0]  cdb_tag;
  logic [DATA_W-1:0] cdb_data;
  logic              iss_valid;
  logic              iss_ready;
  logic [OP_W-1:0]   iss_op;
  logic [DATA_W-1:0] iss_a;
  logic [DATA_W-1:0] iss_b;
  logic [TAG_W-1:0]  iss_dest;
  logic [CNT_W-1:0]  count;

  rs_alu_station #(
    .DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
    .disp_dest(disp_dest), .disp_vj_ok(disp_vj_ok), .disp_vj(disp_vj),
    .disp_qj(disp_qj), .disp_vk_ok(disp_vk_ok), .disp_vk(disp_vk),
    .disp_qk(disp_qk), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .iss_valid(iss_valid), .iss_ready(iss_ready),
    .iss_op(iss_op), .iss_a(iss_a), .iss_b(iss_b), .iss_dest(iss_dest),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [TAG_W-1:0]  dest;
    logic [DATA_W-1:0] vj;
    logic [DATA_W-1:0] vk;
    logic              vj_ok;
    logic              vk_ok;
    logic [TAG_W-1:0]  qj;
    logic [TAG_W-1:0]  qk;
  } ent_t;

  ent_t mq[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int oldest_ready();
    foreach (mq[i]) if (mq[i].vj_ok && mq[i].vk_ok) return i;
    return -1;
  endfunction

  // Compare every DUT output with the model's view of the current cycle.
  task automatic check_model();
    int k;
    logic [OP_W-1:0]   e_op;
    logic [DATA_W-1:0] e_a;
    logic [DATA_W-1:0] e_b;
    logic [TAG_W-1:0]  e_dest;
    k      = oldest_ready();
    e_op   = '0;
    e_a    = '0;
    e_b    = '0;
    e_dest = '0;
    if (k >= 0) begin
      e_op   = mq[k].op;
      e_a    = mq[k].vj;
      e_b    = mq[k].vk;
      e_dest = mq[k].dest;
    end
    check_eq("disp_ready", 64'(disp_ready), 64'(mq.size() < DEPTH));
    check_eq("count",      64'(count),      64'(mq.size()));
    check_eq("iss_valid",  64'(iss_valid),  64'(k >= 0));
    check_eq("iss_op",     64'(iss_op),     64'(e_op));
    check_eq("iss_a",      64'(iss_a),      64'(e_a));
    check_eq("iss_b",      64'(iss_b),      64'(e_b));
    check_eq("iss_dest",   64'(iss_dest),   64'(e_dest));
  endtask

  // Apply one clock edge to the model using the inputs currently driven.
  task automatic model_edge();
    int   k;
    bit   do_iss;
    bit   do_disp;
    ent_t e;
    if (rst || flush) begin
      mq.delete();
      return;
    end
    k       = oldest_ready();
    do_iss  = (k >= 0) && iss_ready;
    do_disp = disp_valid && (mq.size() < DEPTH);
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].vj_ok && mq[i].qj == cdb_tag) begin
          mq[i].vj_ok = 1'b1;
          mq[i].vj    = cdb_data;
        end
        if (!mq[i].vk_ok && mq[i].qk == cdb_tag) begin
          mq[i].vk_ok = 1'b1;
          mq[i].vk    = cdb_data;
        end
      end
    end
    if (do_iss) mq.delete(k);
    if (do_disp) begin
      e.op    = disp_op;
      e.dest  = disp_dest;
      e.qj    = disp_qj;
      e.qk    = disp_qk;
      e.vj_ok = disp_vj_ok;
      e.vj    = disp_vj;
      e.vk_ok = disp_vk_ok;
      e.vk    = disp_vk;
      if (!e.vj_ok && cdb_valid && cdb_tag == e.qj) begin
        e.vj_ok = 1'b1;
        e.vj    = cdb_data;
      end
      if (!e.vk_ok && cdb_valid && cdb_tag == e.qk) begin
        e.vk_ok = 1'b1;
        e.vk    = cdb_data;
      end
      mq.push_back(e);
    end
  endtask

  // Called just after a falling edge: check, take the rising edge, advance
  // the model, and return at the next falling edge.
  task automatic tick(input bit chk = 1'b1);
    if (chk) check_model();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst        = 1'b0;
    flush      = 1'b0;
    disp_valid = 1'b0;
    disp_op    = '0;
    disp_dest  = '0;
    disp_vj_ok = 1'b0;
    disp_vj    = '0;
    disp_qj    = '0;
    disp_vk_ok = 1'b0;
    disp_vk    = '0;
    disp_qk    = '0;
    cdb_valid  = 1'b0;
    cdb_tag    = '0;
    cdb_data   = '0;
    iss_ready  = 1'b0;
  endtask

  task automatic disp(input logic [OP_W-1:0] op, input logic [TAG_W-1:0] dest,
                      input logic vj_ok, input logic [DATA_W-1:0] vj,
                      input logic [TAG_W-1:0] qj, input logic vk_ok,
                      input logic [DATA_W-1:0] vk, input logic [TAG_W-1:0] qk);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_dest  = dest;
    disp_vj_ok = vj_ok;
    disp_vj    = vj;
    disp_qj    = qj;
    disp_vk_ok = vk_ok;
    disp_vk    = vk;
    disp_qk    = qk;
  endtask

  task automatic cdb(input logic [TAG_W-1:0] tag, input logic [DATA_W-1:0] data);
    cdb_valid = 1'b1;
    cdb_tag   = tag;
    cdb_data  = data;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    @(negedge clk);
    tick(1'b0);
    tick(1'b0);
    rst = 1'b0;

    // Reset state.
    check_eq("rst_disp_ready", 64'(disp_ready), 64'd1);
    check_eq("rst_iss_valid",  64'(iss_valid),  64'd0);
    tick();

    // Ready operands issue one cycle after dispatch.
    disp(5'b00010, 4'd3, 1'b1, 32'd5, 4'd0, 1'b1, 32'd7, 4'd0);
    tick();
    disp_valid = 1'b0;
    check_eq("t1_iss_valid", 64'(iss_valid), 64'd1);
    check_eq("t1_iss_a",     64'(iss_a),     64'd5);
    check_eq("t1_iss_b",     64'(iss_b),     64'd7);
    check_eq("t1_iss_dest",  64'(iss_dest),  64'd3);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;
    check_eq("t1_count", 64'(count), 64'd0);
    tick();

    // Wake-up through CDB snoop: eligible one cycle after capture.
    disp(5'b00111, 4'd5, 1'b0, 32'd0, 4'd9, 1'b1, 32'd1, 4'd0);
    tick();
    disp_valid = 1'b0;
    tick();
    check_eq("t2_wait_valid", 64'(iss_valid), 64'd0);
    cdb(4'd9, 32'h20);
    tick();
    cdb_valid = 1'b0;
    check_eq("t2_wake_valid", 64'(iss_valid), 64'd1);
    check_eq("t2_wake_a",     64'(iss_a),     64'h20);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;

    // Dispatch-cycle bypass.
    disp(5'b01000, 4'd6, 1'b0, 32'd0, 4'd4, 1'b1, 32'd2, 4'd0);
    cdb(4'd4, 32'hAB);
    tick();
    disp_valid = 1'b0;
    cdb_valid  = 1'b0;
    check_eq("t3_byp_valid", 64'(iss_valid), 64'd1);
    check_eq("t3_byp_a",     64'(iss_a),     64'hAB);
    iss_ready = 1'b1;
    tick();
    iss_ready = 1'b0;

    // Fill the station; the fifth dispatch is ignored; issue in order.
    for (int i = 0; i < 5; i++) begin
      disp(OP_W'(i), TAG_W'(i + 1), 1'b1, DATA_W'(100 + i), 4'd0,
           1'b1, DATA_W'(200 + i), 4'd0);
      tick();
    end
    disp_valid = 1'b0;
    check_eq("t4_full_count", 64'(count),      64'd4);
    check_eq("t4_full_ready", 64'(disp_ready), 64'd0);
    iss_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t4_order", 64'(iss_dest), 64'(i + 1));
      tick();
    end
    iss_ready = 1'b0;
    check_eq("t4_empty_count", 64'(count), 64'd0);

    // Younger woken first issues first until the older one wakes.
    disp(5'd1, 4'd10, 1'b0, 32'd0, 4'd1, 1'b1, 32'd0, 4'd0);
    tick();
    disp(5'd2, 4'd11, 1'b0, 32'd0, 4'd2, 1'b1, 32'd0, 4'd0);
    tick();
    disp(5'd3, 4'd12, 1'b0, 32'd0, 4'd3, 1'b1, 32'd0, 4'd0);
    tick();
    disp_valid = 1'b0;
    cdb(4'd2, 32'h22);
    tick();
    cdb(4'd3, 32'h33);
    tick();
    cdb_valid = 1'b0;
    check_eq("t5_young_first", 64'(iss_dest), 64'd11);
    cdb(4'd1, 32'h11);
    tick();
    cdb_valid = 1'b0;
    check_eq("t5_old_ahead", 64'(iss_dest), 64'd10);
    iss_ready = 1'b1;
    tick();
    check_eq("t5_then_b", 64'(iss_dest), 64'd11);
    tick();
    check_eq("t5_then_c", 64'(iss_dest), 64'd12);
    tick();
    iss_ready = 1'b0;

    // Flush beats a simultaneous dispatch and CDB broadcast.
    for (int i = 0; i < 3; i++) begin
      disp(5'd4, TAG_W'(i), 1'b1, 32'd9, 4'd0, 1'b0, 32'd0, 4'd7);
      tick();
    end
    flush = 1'b1;
    disp(5'd5, 4'd8, 1'b1, 32'd1, 4'd0, 1'b1, 32'd2, 4'd0);
    cdb(4'd7, 32'h77);
    tick();
    idle();
    check_eq("t6_flush_count", 64'(count),      64'd0);
    check_eq("t6_flush_valid", 64'(iss_valid),  64'd0);
    check_eq("t6_flush_ready", 64'(disp_ready), 64'd1);
    tick();

    // Randomized traffic against the queue model.
    for (int n = 0; n < 1500; n++) begin
      rst        = ($urandom_range(199) == 0);
      flush      = ($urandom_range(49) == 0);
      disp_valid = ($urandom_range(9) < 6);
      disp_op    = OP_W'($urandom);
      disp_dest  = TAG_W'($urandom);
      disp_vj_ok = $urandom_range(1) == 1;
      disp_vj    = $urandom;
      disp_qj    = TAG_W'($urandom_range(7));
      disp_vk_ok = $urandom_range(1) == 1;
      disp_vk    = $urandom;
      disp_qk    = TAG_W'($urandom_range(7));
      cdb_valid  = $urandom_range(1) == 1;
      cdb_tag    = TAG_W'($urandom_range(7));
      cdb_data   = $urandom;
      iss_ready  = ($urandom_range(9) < 6);
      tick();
    end
    idle();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
